// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline blocks.
// Holds the multiply/divide op codes, FSM state encodings and a sign helper.
package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_RUN   = 2'd1;
  localparam logic [1:0] MD_FIX   = 2'd2;

  // Widest value the helper handles; callers zero-extend and truncate back.
  // Two's-complement negation modulo 2^64 truncates to the correct narrower result.
  localparam int MD_MAX_W = 64;

  function automatic logic [MD_MAX_W-1:0] md_cond_neg(input logic [MD_MAX_W-1:0] v,
                                                      input logic               neg);
    return neg ? (~v + MD_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair: synchronous active-low reset, MTHI/MTLO writes and
// multiply/divide result writes (result write wins if both ever coincide).
module hilo_regs #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mt_hi_i,
  input  logic         mt_lo_i,
  input  logic [N-1:0] mt_data_i,
  input  logic         res_we_i,
  input  logic [N-1:0] res_hi_i,
  input  logic [N-1:0] res_lo_i,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  logic [N-1:0] hi_q, hi_d;
  logic [N-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (res_we_i) begin
      hi_d = res_hi_i;
      lo_d = res_lo_i;
    end else begin
      if (mt_hi_i) hi_d = mt_data_i;
      if (mt_lo_i) lo_d = mt_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage with HI/LO registers.
// IDLE latches magnitudes, RUN does N shift-add / restoring-subtract steps, FIX signs and writes.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic         rd_hilo,
  output logic         busy,
  output logic         stall,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * N;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;

  logic          is_div_q, is_div_d;
  logic          dbz_q, dbz_d;
  logic          neg_lo_q, neg_lo_d;
  logic          neg_hi_q, neg_hi_d;
  logic [N-1:0]  acc_hi_q, acc_hi_d;
  logic [N-1:0]  acc_lo_q, acc_lo_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic [N-1:0]  a_raw_q, a_raw_d;

  // Operand decode at start: signed ops work on magnitudes and fix signs in FIX.
  logic          op_signed, sign_a, sign_b;
  logic [N-1:0]  abs_a, abs_b;

  assign op_signed = ~op[0];
  assign sign_a    = op_signed & a[N-1];
  assign sign_b    = op_signed & b[N-1];
  assign abs_a     = N'(md_cond_neg(MD_MAX_W'(a), sign_a));
  assign abs_b     = N'(md_cond_neg(MD_MAX_W'(b), sign_b));

  // Multiply step: {acc_hi, acc_lo} holds partial product above the unconsumed multiplier bits.
  logic [N:0]    mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [N:0]    div_sh;
  logic          div_ge;
  logic [N-1:0]  div_rem;
  assign div_sh  = {acc_hi_q, acc_lo_q[N-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  assign div_rem = div_ge ? N'(div_sh - {1'b0, opnd_q}) : div_sh[N-1:0];

  logic [PW-1:0] prod_fix;
  logic [N-1:0]  quo_fix, rem_fix;
  assign prod_fix = PW'(md_cond_neg(MD_MAX_W'({acc_hi_q, acc_lo_q}), neg_lo_q));
  assign quo_fix  = N'(md_cond_neg(MD_MAX_W'(acc_lo_q), neg_lo_q));
  assign rem_fix  = N'(md_cond_neg(MD_MAX_W'(acc_hi_q), neg_hi_q));

  logic          res_we;
  logic [N-1:0]  res_hi, res_lo;
  logic          mt_hi_we, mt_lo_we;

  // start in IDLE takes priority; MT writes are only honoured when the unit is free.
  assign mt_hi_we = (state_q == MD_IDLE) & ~start & mthi;
  assign mt_lo_we = (state_q == MD_IDLE) & ~start & mtlo;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    res_we   = 1'b0;
    res_hi   = '0;
    res_lo   = '0;

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d  = MD_RUN;
          count_d  = CW'(N - 1);
          is_div_d = op[1];
          dbz_d    = op[1] & (b == '0);
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          a_raw_d  = a;
          acc_hi_d = '0;
          if (op[1]) begin
            acc_lo_d = abs_a;
            opnd_d   = abs_b;
          end else begin
            acc_lo_d = abs_b;
            opnd_d   = abs_a;
          end
        end
      end

      MD_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[N-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[N:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[N-1:1]};
        end
        if (count_q == '0) state_d = MD_FIX;
        else               count_d = count_q - CW'(1);
      end

      MD_FIX: begin
        state_d = MD_IDLE;
        done_d  = 1'b1;
        res_we  = 1'b1;
        if (!is_div_q) begin
          res_hi = prod_fix[PW-1:N];
          res_lo = prod_fix[N-1:0];
        end else if (dbz_q) begin
          res_hi = a_raw_q;
          res_lo = '1;
        end else begin
          res_hi = rem_fix;
          res_lo = quo_fix;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded at start before being read.
  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    dbz_q    <= dbz_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    opnd_q   <= opnd_d;
    a_raw_q  <= a_raw_d;
  end

  hilo_regs #(.N(N)) u_hilo_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .mt_hi_i   (mt_hi_we),
    .mt_lo_i   (mt_lo_we),
    .mt_data_i (a),
    .res_we_i  (res_we),
    .res_hi_i  (res_hi),
    .res_lo_i  (res_lo),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  assign busy  = (state_q != MD_IDLE);
  assign stall = busy & (start | mthi | mtlo | rd_hilo);
  assign done  = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO, a negedge monitor
// pops and compares on every done pulse.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, mthi, mtlo, rd_hilo;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.N(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .rd_hilo (rd_hilo),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
    res_t e;
    e.hi = eh;
    e.lo = el;
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
        end
      end
    end
  end

  // Counts edges until done (bounded); lat is the done cycle relative to the cycle
  // the caller was in, bc counts busy cycles seen before it.
  task automatic wait_done(input bit drop_start, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1 && drop_start) begin
        start = 1'b0;
        a     = ~a;
        b     = b ^ 32'h5a5a_a5a5;
      end
      if (done) break;
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    int lat, bc;
    push_exp(eh, el);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    wait_done(1'b1, lat, bc);
    check({name, "_latency"}, lat, 34);
    check({name, "_busy_cycles"}, bc, 33);
    check({name, "_busy_at_done"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int lat, bc, stall_bad, hold_bad, done_seen;

    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_hilo = 1'b0;
    op = MD_MULT; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("multu_max", MD_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001);
    run_op("mult_neg",  MD_MULT,  32'hffff_fffd, 32'd7,         32'hffff_ffff, 32'hffff_ffeb);
    run_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_neg_a", MD_DIV,   32'hffff_fff9, 32'd2,         32'hffff_ffff, 32'hffff_fffd);
    run_op("div_neg_b", MD_DIV,   32'd7,         32'hffff_fffe, 32'h0000_0001, 32'hffff_fffd);
    run_op("divu_zero", MD_DIVU,  32'd7,         32'h0,         32'h0000_0007, 32'hffff_ffff);
    run_op("div_zero",  MD_DIV,   32'hffff_fffb, 32'h0,         32'hffff_fffb, 32'hffff_ffff);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hffff_ffff, 32'h0,         32'h8000_0000);
    run_op("divu_rem",  MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);

    // Busy-time hazards: rd_hilo plus a second start and an mthi held across the op.
    push_exp(32'd0, 32'd15);
    push_exp(32'd1, 32'd11);
    op = MD_MULTU; a = 32'd3; b = 32'd5; start = 1'b1; rd_hilo = 1'b1;
    @(posedge clk);
    #1;
    op = MD_DIVU; a = 32'd100; b = 32'd9; mthi = 1'b1;
    lat = 1; bc = 0; stall_bad = 0; hold_bad = 0;
    while (!done && lat < 100) begin
      if (busy) begin
        bc++;
        if (stall !== 1'b1) stall_bad++;
        if (hi !== 32'd2 || lo !== 32'd14) hold_bad++;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check("hz_latency", lat, 34);
    check("hz_busy_cycles", bc, 33);
    check("hz_stall_while_busy", stall_bad, 0);
    check("hz_hilo_held", hold_bad, 0);
    check("hz_stall_at_done", stall, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; rd_hilo = 1'b0;
    check("hz_reissue_busy", busy, 1'b1);
    check("hz_mthi_dropped", hi, 32'd0);
    wait_done(1'b0, lat, bc);
    check("hz2_latency", lat, 33);

    // Reset in the middle of a divide abandons it without a result.
    @(posedge clk);
    #1;
    op = MD_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_div_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    mtlo = 1'b1; a = 32'h1234;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi", hi, 32'h0);
    mthi = 1'b1; a = 32'hbeef;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hbeef);
    check("mthi_lo", lo, 32'h1234);
    mthi = 1'b1; mtlo = 1'b1; a = 32'hcafe;
    @(posedge clk);
    #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", hi, 32'hcafe);
    check("mtboth_lo", lo, 32'hcafe);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
